counter_4bit: RTL and testbench

//   Free-running binary up-counter with synchronous clear and count enable.

---
 rtl/counter_4bit.sv | 50 +++++
 tb/tb_counter_4bit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/counter_4bit.sv
// Binary up-counter with synchronous clear, count enable and terminal-count flag.
// cnt is registered (one edge per increment); tc is combinational; no backpressure.
// Optional COUNTER_SATURATE_EN: hold at MAX_VALUE instead of wrapping to 0.
module counter_4bit #(
  parameter int unsigned         WIDTH     = 4,
  parameter logic [WIDTH-1:0]    MAX_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == MAX_VALUE);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
`ifdef COUNTER_SATURATE_EN
      if (!at_max) begin
        cnt_d = cnt_q + 1'b1;
      end
`else
      // Explicit wrap so a MAX_VALUE below 2^WIDTH-1 gives a shorter modulus.
      if (at_max) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = at_max && en;

endmodule

// File: tb/tb_counter_4bit.sv
// Directed bench for counter_4bit: default 4-bit instance plus a MAX_VALUE=9 instance.
// Expected values follow wrap or saturate behaviour depending on COUNTER_SATURATE_EN.
module tb_counter_4bit;

  logic       clk;
  logic       clr;
  logic       en;
  logic [3:0] cnt;
  logic       tc;
  logic       clr9;
  logic       en9;
  logic [3:0] cnt9;
  logic       tc9;

  int checks   = 0;
  int failures = 0;
  int tc_seen  = 0;

  counter_4bit dut (
    .clk (clk),
    .clr (clr),
    .en  (en),
    .cnt (cnt),
    .tc  (tc)
  );

  counter_4bit #(.WIDTH(4), .MAX_VALUE(4'd9)) dut9 (
    .clk (clk),
    .clr (clr9),
    .en  (en9),
    .cnt (cnt9),
    .tc  (tc9)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected count after n enabled edges from zero, for terminal value maxv.
  function automatic int model(int n, int maxv);
`ifdef COUNTER_SATURATE_EN
    return (n > maxv) ? maxv : n;
`else
    return n % (maxv + 1);
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    clr  = 1'b1;
    en   = 1'b0;
    clr9 = 1'b1;
    en9  = 1'b0;

    // Reset
    step();
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_tc", int'(tc), 0);
    chk("reset_cnt9", int'(cnt9), 0);

    // Count 32 edges
    clr = 1'b0;
    en  = 1'b1;
    #1;
    chk("count_tc_at0", int'(tc), 0);
    for (int i = 1; i <= 32; i++) begin
      step();
      e = model(i, 15);
      chk($sformatf("count_cnt[%0d]", i), int'(cnt), e);
      chk($sformatf("count_tc[%0d]", i), int'(tc), (e == 15) ? 1 : 0);
      if (tc === 1'b1) tc_seen++;
    end
`ifdef COUNTER_SATURATE_EN
    chk("count_tc_cycles", tc_seen, 18);
`else
    chk("count_tc_cycles", tc_seen, 2);
`endif

    // Hold at 7
    clr = 1'b1;
    step();
    chk("clear_before_hold", int'(cnt), 0);
    clr = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("reach_7", int'(cnt), 7);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_cnt[%0d]", i), int'(cnt), 7);
      chk($sformatf("hold_tc[%0d]", i), int'(tc), 0);
    end
    en = 1'b1;
    step();
    chk("resume_8", int'(cnt), 8);
    step();
    chk("reach_9", int'(cnt), 9);

    // Clear has priority over enable
    clr = 1'b1;
    step();
    chk("clr_priority", int'(cnt), 0);
    clr = 1'b0;
    step();
    chk("after_clr_1", int'(cnt), 1);

    // Long enabled run after clear: saturates or wraps
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      e = model(i, 15);
      chk($sformatf("run20_cnt[%0d]", i), int'(cnt), e);
      chk($sformatf("run20_tc[%0d]", i), int'(tc), (e == 15) ? 1 : 0);
    end
    // Drive the count to 15 under either mode, then check tc gating by en
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("at15_cnt", int'(cnt), 15);
    chk("at15_tc_en1", int'(tc), 1);
    en = 1'b0;
    #1;
    chk("at15_tc_en0", int'(tc), 0);
    clr = 1'b1;
    step();
    chk("final_clr", int'(cnt), 0);
    clr = 1'b0;

    // MAX_VALUE = 9 instance
    clr9 = 1'b0;
    en9  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("mod10_cnt[%0d]", i), int'(cnt9), i);
      chk($sformatf("mod10_tc[%0d]", i), int'(tc9), (i == 9) ? 1 : 0);
    end
    en9 = 1'b0;
    #1;
    chk("mod10_tc_en0", int'(tc9), 0);
    step();
    chk("mod10_hold", int'(cnt9), 9);
    en9 = 1'b1;
    step();
    chk("mod10_wrap", int'(cnt9), model(10, 9));
    step();
    chk("mod10_next", int'(cnt9), model(11, 9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
